// File: rtl/eth_tx_fsm_if.sv
// Port bundle for the Ethernet transmit framer: frame request, buffer read port
// and the byte stream handed to the ODDR output stage.
interface eth_tx_fsm_if;
   logic        i_start;
   logic [47:0] i_dest_mac;
   logic [47:0] i_src_mac;
   logic [15:0] i_payload_length;
   logic [15:0] i_base_addr;
   logic [15:0] o_eth_mem_rd_addr;
   logic        o_eth_mem_re;
   logic [7:0]  i_eth_mem_data_8b;
   logic [7:0]  o_eth_txd_8b;
   logic        o_eth_tx_en;
   logic        o_busy;
   logic        o_done;
   logic [9:0]  o_packet_count;

   modport master (
      output i_start, i_dest_mac, i_src_mac, i_payload_length, i_base_addr,
      output i_eth_mem_data_8b,
      input  o_eth_mem_rd_addr, o_eth_mem_re, o_eth_txd_8b, o_eth_tx_en,
      input  o_busy, o_done, o_packet_count
   );

   modport slave (
      input  i_start, i_dest_mac, i_src_mac, i_payload_length, i_base_addr,
      input  i_eth_mem_data_8b,
      output o_eth_mem_rd_addr, o_eth_mem_re, o_eth_txd_8b, o_eth_tx_en,
      output o_busy, o_done, o_packet_count
   );
endinterface

// File: rtl/eth_tx_fsm.sv
// Ethernet II transmit framer: preamble/SFD, MAC header, length, buffered payload,
// CRC-32 FCS and inter-frame gap, one registered byte per clock.
module eth_tx_fsm #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12,
   parameter int MAX_PAYLOAD    = 1500
) (
   input logic         i_eth_clk,
   input logic         i_rst,
   eth_tx_fsm_if.slave tx
);

   typedef enum logic [3:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_DEST, S_SRC, S_LEN, S_PAYLOAD, S_FCS, S_IFG
   } state_t;

   localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

   // state/cnt name the byte currently presented on the output register
   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;

   logic [47:0] dest_q, src_q;
   logic [15:0] len_q, base_q;
   logic [15:0] len_clamped;
   logic        accept;

   logic [31:0] crc;
   logic [31:0] fcs;
   logic        crc_en;
   logic [2:0]  fld_idx;

   logic [7:0]  txd_d;
   logic        tx_en_d;
   logic        done_d;
   logic        rd_begin;

   logic [7:0]  txd_q;
   logic        tx_en_q;
   logic        re_q;
   logic [15:0] rd_addr_q;
   logic [15:0] rd_left;
   logic        done_q;
   logic [9:0]  pkt_q;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign accept      = (state == S_IDLE) && tx.i_start;
   assign len_clamped = (tx.i_payload_length > MAX_LEN) ? MAX_LEN : tx.i_payload_length;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 16'd1;
      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (tx.i_start) state_nxt = S_PREAMBLE;
         end
         S_PREAMBLE: if (cnt == PRE_LAST) begin state_nxt = S_SFD; cnt_nxt = '0; end
         S_SFD:      begin state_nxt = S_DEST; cnt_nxt = '0; end
         S_DEST:     if (cnt == 16'd5) begin state_nxt = S_SRC; cnt_nxt = '0; end
         S_SRC:      if (cnt == 16'd5) begin state_nxt = S_LEN; cnt_nxt = '0; end
         S_LEN: begin
            if (cnt == 16'd1) begin
               state_nxt = (len_q == '0) ? S_FCS : S_PAYLOAD;
               cnt_nxt   = '0;
            end
         end
         S_PAYLOAD:  if (cnt == len_q - 16'd1) begin state_nxt = S_FCS; cnt_nxt = '0; end
         S_FCS:      if (cnt == 16'd3) begin state_nxt = S_IFG; cnt_nxt = '0; end
         S_IFG:      if (cnt == IFG_LAST) begin state_nxt = S_IDLE; cnt_nxt = '0; end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Byte to register for the position being entered; payload data arrives from the read issued last cycle
   always_comb begin
      fld_idx  = 3'd5 - cnt_nxt[2:0];
      fcs      = ~crc;
      txd_d    = 8'h00;
      tx_en_d  = 1'b1;
      crc_en   = 1'b0;
      done_d   = (state_nxt == S_IFG) && (state != S_IFG);
      rd_begin = (state_nxt == S_LEN) && (state != S_LEN) && (len_q != '0);
      case (state_nxt)
         S_PREAMBLE: txd_d = 8'h55;
         S_SFD:      txd_d = 8'hD5;
         S_DEST: begin
            txd_d  = 8'(dest_q >> {fld_idx, 3'b000});
            crc_en = 1'b1;
         end
         S_SRC: begin
            txd_d  = 8'(src_q >> {fld_idx, 3'b000});
            crc_en = 1'b1;
         end
         S_LEN: begin
            txd_d  = cnt_nxt[0] ? len_q[7:0] : len_q[15:8];
            crc_en = 1'b1;
         end
         S_PAYLOAD: begin
            txd_d  = tx.i_eth_mem_data_8b;
            crc_en = 1'b1;
         end
         S_FCS:   txd_d = 8'(fcs >> {cnt_nxt[1:0], 3'b000});
         default: tx_en_d = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_eth_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         txd_q     <= '0;
         tx_en_q   <= 1'b0;
         re_q      <= 1'b0;
         rd_addr_q <= '0;
         rd_left   <= '0;
         done_q    <= 1'b0;
         pkt_q     <= '0;
         crc       <= '1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         txd_q   <= txd_d;
         tx_en_q <= tx_en_d;
         done_q  <= done_d;
         if (done_d && (pkt_q != 10'h3FF)) pkt_q <= pkt_q + 10'd1;

         if (accept)      crc <= '1;
         else if (crc_en) crc <= crc32_byte(crc, txd_d);

         // Reads run two cycles ahead of the byte they feed, starting with the first length byte
         if (rd_begin) begin
            re_q      <= 1'b1;
            rd_addr_q <= base_q;
            rd_left   <= len_q - 16'd1;
         end else if (re_q && (rd_left != '0)) begin
            rd_addr_q <= rd_addr_q + 16'd1;
            rd_left   <= rd_left - 16'd1;
         end else begin
            re_q <= 1'b0;
         end
      end
   end

   // NOTE: frame parameters carry no reset; they are always loaded on accept before being used.
   always_ff @(posedge i_eth_clk) begin
      if (accept) begin
         dest_q <= tx.i_dest_mac;
         src_q  <= tx.i_src_mac;
         len_q  <= len_clamped;
         base_q <= tx.i_base_addr;
      end
   end

   assign tx.o_eth_txd_8b      = txd_q;
   assign tx.o_eth_tx_en       = tx_en_q;
   assign tx.o_eth_mem_re      = re_q;
   assign tx.o_eth_mem_rd_addr = rd_addr_q;
   assign tx.o_busy            = (state != S_IDLE);
   assign tx.o_done            = done_q;
   assign tx.o_packet_count    = pkt_q;

endmodule

// File: tb/tb_eth_tx_fsm.sv
// Scoreboard bench for eth_tx_fsm: stimulus queues expected bytes/reads/lengths,
// a negedge monitor pops and compares whatever the framer presents.
module tb_eth_tx_fsm;
   localparam int PRE  = 7;
   localparam int IFG  = 12;
   localparam int MAXP = 1500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eth_tx_fsm_if ifc ();

   eth_tx_fsm #(
      .PREAMBLE_BYTES(PRE),
      .IFG_BYTES     (IFG),
      .MAX_PAYLOAD   (MAXP)
   ) dut (
      .i_eth_clk(clk),
      .i_rst    (rst),
      .tx       (ifc)
   );

   // Transmit buffer: one-cycle read latency
   logic [7:0] mem [0:65535];
   always @(posedge clk)
      if (ifc.o_eth_mem_re) ifc.i_eth_mem_data_8b <= mem[ifc.o_eth_mem_rd_addr];

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_bytes [$];
   int          exp_len   [$];
   logic [15:0] exp_addr  [$];

   logic [31:0] crc_tab [256];

   int cyc            = 0;
   int frames_started = 0;
   int frames_ended   = 0;
   int spacing_exp    = 0;
   int last_rise      = -1;

   // Header for the directed N=4 frame: dest, src, length, payload
   logic [7:0] hand_hdr [18] = '{8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h6F,
                                 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                 8'h00, 8'h04,
                                 8'hDE, 8'hAD, 8'hBE, 8'hEF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      return (c >> 8) ^ crc_tab[c[7:0] ^ b];
   endfunction

   task automatic build_crc_table();
      logic [31:0] r;
      for (int i = 0; i < 256; i++) begin
         r = 32'(i);
         for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
         crc_tab[i] = r;
      end
   endtask

   task automatic push_fcs(input logic [7:0] hdr [$]);
      logic [31:0] c;
      c = '1;
      foreach (hdr[i]) begin
         c = crc_upd(c, hdr[i]);
         exp_bytes.push_back(hdr[i]);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_bytes.push_back(c[8*i +: 8]);
   endtask

   task automatic push_frame(input logic [47:0] dst, input logic [47:0] srcm,
                             input logic [15:0] len_raw, input logic [15:0] base);
      int n;
      logic [7:0] hdr [$];
      n = (int'(len_raw) > MAXP) ? MAXP : int'(len_raw);
      for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
      exp_bytes.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) hdr.push_back(dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) hdr.push_back(srcm[8*i +: 8]);
      hdr.push_back(8'(n >> 8));
      hdr.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
         logic [15:0] a;
         a = base + 16'(k);
         hdr.push_back(mem[a]);
         exp_addr.push_back(a);
      end
      push_fcs(hdr);
      exp_len.push_back(PRE + 1 + 14 + n + 4);
   endtask

   task automatic send(input logic [47:0] dst, input logic [47:0] srcm,
                       input logic [15:0] len_raw, input logic [15:0] base);
      ifc.i_dest_mac       = dst;
      ifc.i_src_mac        = srcm;
      ifc.i_payload_length = len_raw;
      ifc.i_base_addr      = base;
      ifc.i_start          = 1'b1;
      @(posedge clk); #1;
      ifc.i_start          = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k;
      k = 0;
      while ((exp_bytes.size() != 0 || ifc.o_busy) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= budget) begin
         errors++;
         checks++;
         $display("FAIL %s timeout: still busy after %0d cycles, expected idle", tag, k);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      int          run_len;
      int          rx_idx;
      logic [31:0] rx_crc;
      logic        tx_prev;
      run_len = 0;
      rx_idx  = 0;
      rx_crc  = '1;
      tx_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_bytes.delete();
            exp_len.delete();
            exp_addr.delete();
            tx_prev        = 1'b0;
            frames_started = 0;
            frames_ended   = 0;
         end else begin
            if (ifc.o_eth_tx_en) begin
               if (!tx_prev) begin
                  run_len = 0;
                  rx_idx  = 0;
                  rx_crc  = '1;
                  frames_started++;
                  if (spacing_exp != 0 && last_rise >= 0)
                     check("start spacing", 32'(cyc - last_rise), 32'(spacing_exp));
                  last_rise = cyc;
               end
               run_len++;
               if (exp_bytes.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL tx byte: got 0x%0h, expected no frame", ifc.o_eth_txd_8b);
               end else begin
                  check("tx byte", 32'(ifc.o_eth_txd_8b), 32'(exp_bytes.pop_front()));
               end
               if (rx_idx >= PRE + 1) rx_crc = crc_upd(rx_crc, ifc.o_eth_txd_8b);
               rx_idx++;
               check("done low in frame", 32'(ifc.o_done), 32'd0);
            end else begin
               check("idle txd", 32'(ifc.o_eth_txd_8b), 32'd0);
               if (tx_prev) begin
                  frames_ended++;
                  check("done at frame end", 32'(ifc.o_done), 32'd1);
                  check("busy into ifg", 32'(ifc.o_busy), 32'd1);
                  check("crc residue", rx_crc, 32'hDEBB_20E3);
                  if (exp_len.size() == 0) begin
                     errors++;
                     checks++;
                     $display("FAIL tx_en length: got %0d, expected no frame", run_len);
                  end else begin
                     check("tx_en length", 32'(run_len), 32'(exp_len.pop_front()));
                  end
                  check("packet count", 32'(ifc.o_packet_count),
                        32'((frames_ended > 1023) ? 1023 : frames_ended));
               end else begin
                  check("done idle", 32'(ifc.o_done), 32'd0);
               end
            end
            if (ifc.o_eth_mem_re) begin
               if (exp_addr.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL read addr: got 0x%0h, expected no read", ifc.o_eth_mem_rd_addr);
               end else begin
                  check("read addr", 32'(ifc.o_eth_mem_rd_addr), 32'(exp_addr.pop_front()));
               end
            end
            tx_prev = ifc.o_eth_tx_en;
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] hdr [$];
      int         bc;
      int         k;
      logic [15:0] lens [4] = '{16'd0, 16'd1, 16'd46, 16'd1500};

      build_crc_table();
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom());
      mem[16'h0400] = 8'hDE;
      mem[16'h0401] = 8'hAD;
      mem[16'h0402] = 8'hBE;
      mem[16'h0403] = 8'hEF;

      ifc.i_start          = 1'b0;
      ifc.i_dest_mac       = '0;
      ifc.i_src_mac        = '0;
      ifc.i_payload_length = '0;
      ifc.i_base_addr      = '0;

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset txd", 32'(ifc.o_eth_txd_8b), 32'd0);
      check("reset tx_en", 32'(ifc.o_eth_tx_en), 32'd0);
      check("reset re", 32'(ifc.o_eth_mem_re), 32'd0);
      check("reset rd_addr", 32'(ifc.o_eth_mem_rd_addr), 32'd0);
      check("reset busy", 32'(ifc.o_busy), 32'd0);
      check("reset done", 32'(ifc.o_done), 32'd0);
      check("reset count", 32'(ifc.o_packet_count), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed N=4 frame with hand-written header and payload
      for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
      exp_bytes.push_back(8'hD5);
      foreach (hand_hdr[i]) hdr.push_back(hand_hdr[i]);
      push_fcs(hdr);
      exp_len.push_back(30);
      exp_addr.push_back(16'h0400);
      exp_addr.push_back(16'h0401);
      exp_addr.push_back(16'h0402);
      exp_addr.push_back(16'h0403);
      send(48'h1A2B_3C4D_5E6F, 48'h0011_2233_4455, 16'd4, 16'h0400);
      @(negedge clk);
      check("accept tx_en", 32'(ifc.o_eth_tx_en), 32'd1);
      check("accept busy", 32'(ifc.o_busy), 32'd1);
      bc = 0;
      while (ifc.o_busy && bc < 200) begin
         bc++;
         @(negedge clk);
      end
      check("busy cycles n4", 32'(bc), 32'd42);
      check("count after n4", 32'(ifc.o_packet_count), 32'd1);
      @(posedge clk); #1;
      wait_idle(100, "n4");

      // CRC frames with random content
      foreach (lens[i]) begin
         logic [47:0] d, s;
         logic [15:0] b;
         d = {$urandom(), 16'($urandom())};
         s = {$urandom(), 16'($urandom())};
         b = 16'($urandom());
         push_frame(d, s, lens[i], b);
         send(d, s, lens[i], b);
         wait_idle(2000, "crc frame");
      end

      // Length clamp
      push_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'd2000, 16'h8000);
      send(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'd2000, 16'h8000);
      wait_idle(2000, "clamp");

      // Start ignored while busy; inputs changed after accept have no effect
      push_frame(48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516, 16'd8, 16'h2000);
      send(48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516, 16'd8, 16'h2000);
      ifc.i_dest_mac       = 48'hDEAD_BEEF_0000;
      ifc.i_payload_length = 16'd3;
      ifc.i_base_addr      = 16'h5555;
      repeat (10) @(posedge clk);
      #1;
      ifc.i_start = 1'b1;
      @(posedge clk); #1;
      ifc.i_start = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      ifc.i_start = 1'b1;
      @(posedge clk); #1;
      ifc.i_start = 1'b0;
      wait_idle(200, "start ignored");
      repeat (50) @(posedge clk);
      #1;
      check("no second frame", 32'(ifc.o_busy), 32'd0);

      // Address wrap
      push_frame(48'h0000_0000_0001, 48'h0000_0000_0002, 16'd4, 16'hFFFE);
      send(48'h0000_0000_0001, 48'h0000_0000_0002, 16'd4, 16'hFFFE);
      wait_idle(200, "wrap");

      // Reset during payload
      push_frame(48'h1111_2222_3333, 48'h4444_5555_6666, 16'd20, 16'h1234);
      send(48'h1111_2222_3333, 48'h4444_5555_6666, 16'd20, 16'h1234);
      repeat (25) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst tx_en", 32'(ifc.o_eth_tx_en), 32'd0);
      check("rst re", 32'(ifc.o_eth_mem_re), 32'd0);
      check("rst busy", 32'(ifc.o_busy), 32'd0);
      check("rst txd", 32'(ifc.o_eth_txd_8b), 32'd0);
      check("rst count", 32'(ifc.o_packet_count), 32'd0);
      @(posedge clk); #1;
      push_frame(48'h1111_2222_3333, 48'h4444_5555_6666, 16'd20, 16'h1234);
      send(48'h1111_2222_3333, 48'h4444_5555_6666, 16'd20, 16'h1234);
      wait_idle(200, "after reset");

      // Start held high: back-to-back frames and count saturation
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      spacing_exp = PRE + 1 + 14 + 4 + IFG + 1;
      last_rise   = -1;
      for (int i = 0; i < 1025; i++) push_frame(48'h00AA_BBCC_DDEE, 48'h0012_3456_789A, 16'd0, 16'h0000);
      ifc.i_dest_mac       = 48'h00AA_BBCC_DDEE;
      ifc.i_src_mac        = 48'h0012_3456_789A;
      ifc.i_payload_length = 16'd0;
      ifc.i_base_addr      = 16'h0000;
      ifc.i_start          = 1'b1;
      k = 0;
      while (frames_started < 1025 && k < 1025 * 40 + 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (frames_started < 1025) begin
         errors++;
         checks++;
         $display("FAIL held start timeout: got %0d frames, expected 1025", frames_started);
      end
      ifc.i_start = 1'b0;
      wait_idle(200, "held start");
      spacing_exp = 0;
      check("count saturated", 32'(ifc.o_packet_count), 32'd1023);

      check("leftover bytes", 32'(exp_bytes.size()), 32'd0);
      check("leftover reads", 32'(exp_addr.size()), 32'd0);
      check("leftover frames", 32'(exp_len.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_tx_fsm.md
# eth_tx_fsm

Transmit-side framing engine for the RGMII Ethernet transceiver. On a start pulse it emits one complete Ethernet II frame, byte-wide, on the transmit clock domain:

- preamble, SFD, destination MAC, source MAC and length field;
- payload read from a byte-wide transmit buffer memory;
- CRC-32 FCS computed in-block;
- inter-frame gap.

It sits between the transmit buffer memory and the ODDR output stage, which splits each byte into nibbles, low nibble on the rising edge.

## Interface
Parameters:
- PREAMBLE_BYTES, 7: count of 0x55 bytes before the SFD.
- IFG_BYTES, 12: idle cycles after the FCS, before returning to idle.
- MAX_PAYLOAD, 1500: payload length clamp.

Ports:
- i_eth_clk  in  1  transmit clock. One clock domain only.
- i_rst  in  1  reset. Synchronous, active-high.
- i_start  in  1  request to send one frame. Sampled only in S_IDLE.
- i_dest_mac  in  48  destination MAC. Captured on accept.
- i_src_mac  in  48  source MAC. Captured on accept.
- i_payload_length  in  16  payload byte count. Captured on accept.
- i_base_addr  in  16  buffer address of payload byte 0. Captured on accept.
- o_eth_mem_rd_addr  out  16  buffer read address.
- o_eth_mem_re  out  1  buffer read enable.
- i_eth_mem_data_8b  in  8  buffer read data. Valid the cycle after o_eth_mem_re.
- o_eth_txd_8b  out  8  transmit byte to the ODDR stage. Registered.
- o_eth_tx_en  out  1  frame-valid to the ODDR stage (TX_CTL). Registered.
- o_busy  out  1  frame in progress, including the IFG.
- o_done  out  1  one-cycle pulse at frame end.
- o_packet_count  out  10  frames sent. Saturates at 1023.

## Operation
States and transitions:
- S_IDLE: accept when i_start=1. Go to S_PREAMBLE.
- S_PREAMBLE: PREAMBLE_BYTES cycles of 0x55.
- S_SFD: 1 cycle of 0xD5.
- S_DEST: 6 bytes, MSB byte first.
- S_SRC: 6 bytes, MSB byte first.
- S_LEN: 2 bytes, [15:8] first.
- S_PAYLOAD: N bytes. Skipped when N=0.
- S_FCS: 4 bytes.
- S_IFG: IFG_BYTES cycles, then S_IDLE.

Field values:
- N = min(i_payload_length, MAX_PAYLOAD). The length field transmits N, not the raw input.
- No padding to 46 bytes; the paired receiver reads exactly the length field.

CRC-32:
- Reflected polynomial 0xEDB88320, 8 bits per cycle, LSB-first within each byte.
- Register initialised to 0xFFFFFFFF on accept.
- Updated with every byte of S_DEST, S_SRC, S_LEN and S_PAYLOAD; nothing else.
- FCS = ~crc, sent as [7:0], [15:8], [23:16], [31:24].

Payload reads:
- Byte k is read from address i_base_addr+k. Addresses wrap modulo 2^16.
- o_eth_mem_re is high for exactly N cycles per frame and low at all other times.

Outputs by state:
- o_eth_tx_en=1 from the first preamble byte through the last FCS byte; 0 otherwise.
- o_eth_txd_8b=0x00 whenever o_eth_tx_en=0.

Counters and status:
- o_done pulses with the first S_IFG cycle.
- o_packet_count increments in that same cycle, saturating at 1023.

Boundary conditions:
- i_start while busy: ignored. Not queued.
- i_start held high: a new frame is accepted on the first S_IDLE cycle after the IFG.
- Input changes after accept: no effect on the frame in progress.
- i_rst mid-frame: the next edge forces S_IDLE and all outputs to reset values. The frame is truncated with no FCS, and o_packet_count clears.

## Timing
Reset values:
- o_eth_txd_8b=0, o_eth_tx_en=0.
- o_eth_mem_re=0, o_eth_mem_rd_addr=0.
- o_busy=0, o_done=0, o_packet_count=0.

Accept and framing:
- Accept edge T: i_start=1 in S_IDLE.
- After T: o_busy=1, o_eth_tx_en=1, o_eth_txd_8b=0x55.
- Frame length in tx_en cycles: PREAMBLE_BYTES+1+14+N+4, i.e. 26+N with defaults.

Payload read pipeline:
- The read for payload byte k is issued exactly 2 cycles before byte k appears on o_eth_txd_8b.
- The first read (k=0) is therefore issued with the first S_LEN byte.
- Payload bytes are back-to-back; no bubbles.

Frame end:
- o_busy falls the cycle after the last S_IFG cycle.
- Start-to-start minimum period: 26+N+IFG_BYTES+1 cycles.

## Test plan
- N=4 frame:
  - Stimulus: dest=0x1A2B3C4D5E6F, src=0x001122334455, length=4, buffer at base 0x0400 = DE AD BE EF.
  - Required stream: 7×55, D5, 1A 2B 3C 4D 5E 6F, 00 11 22 33 44 55, 00 04, DE AD BE EF, 4 FCS bytes.
  - tx_en high for exactly 30 cycles; reads at 0x0400–0x0403 each 2 cycles ahead; o_done after 30; o_packet_count=1.
- CRC check:
  - Stimulus: random dest, src and payload, N in {0, 1, 46, 1500}.
  - Required: CRC-32 over bytes 8..end, FCS included, leaves residue register 0xDEBB20E3; a reference model matches the FCS.
- N=0 and clamp:
  - Stimulus: length=0.
  - Required: 26 tx_en cycles, o_eth_mem_re never asserted, length field 00 00.
  - Stimulus: length=2000.
  - Required: field 05 DC, 1500 payload bytes.
- Start handling:
  - Stimulus: i_start pulsed mid-frame and during the IFG.
  - Required: ignored; one frame only.
  - Stimulus: i_start held high.
  - Required: frames at exactly 26+N+13 cycle spacing; count reaches 1023 and holds.
- Address wrap and reset:
  - Stimulus: base=0xFFFE, N=4.
  - Required: reads FFFE, FFFF, 0000, 0001.
  - Stimulus: i_rst asserted during S_PAYLOAD.
  - Required: tx_en=0, re=0 and busy=0 the next cycle; the next i_start yields a correct full frame.
